// File: rtl/display_scan_ctrl_pkg.sv
// Shared types, blanking constants and the hex-to-7-segment table
// for the multiplexed display controller.
package disp_pkg;

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-high segment code, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high 7-segment decoder.
module hex7seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex7(nibble);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with per-slot blanking, leading-zero
// suppression and frame-aligned commit of loaded display values.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int SCAN_LIM  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic [4*N_DIG-1:0] i_Data,
    input  logic [N_DIG-1:0]   i_Dp,
    input  logic               i_Lz,
    input  logic               i_Load,
    output logic               o_Ack,
    output logic               o_Frame,
    output logic [N_DIG-1:0]   o_An,
    output logic [6:0]         o_Seg,
    output logic               o_Dp
);

    localparam int CNT_W = $clog2(SCAN_LIM);
    localparam int IDX_W = $clog2(N_DIG);

    state_t             state, state_nxt;
    logic               run;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [4*N_DIG-1:0] disp_reg, pend_reg;
    logic [N_DIG-1:0]   dp_reg, pend_dp;
    logic               pend;

    logic               cnt_wrap, frame_wrap, commit;
    logic [3:0]         nib_sel;
    logic               dp_sel, supp_sel, upper_zero;
    logic [N_DIG-1:0]   an_sel, lz_mask;
    logic [6:0]         seg_dec;
    logic [N_DIG-1:0]   an_n;
    logic [6:0]         seg_n;
    logic               dp_n;

    // The first edge after reset only primes the outputs for cnt=0/idx=0,
    // so the opening frame gets its o_Frame pulse like every later one.
    always_comb begin
        cnt_wrap   = run && (cnt == CNT_W'(SCAN_LIM - 1));
        frame_wrap = cnt_wrap && (idx == IDX_W'(N_DIG - 1));
        commit     = frame_wrap && pend && !i_Load;
        cnt_nxt    = (!run || cnt_wrap) ? '0 : cnt + CNT_W'(1);
        idx_nxt    = idx;
        if (cnt_wrap) begin
            idx_nxt = (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= S_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BLANK: if (run && cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = S_SHOW;
            S_SHOW:  if (cnt_wrap) state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
    end

    // A digit is a leading zero when it and every more significant nibble are 0
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            upper_zero = upper_zero && (disp_reg[4*(N_DIG-1-i) +: 4] == 4'h0);
            lz_mask[N_DIG-1-i] = upper_zero && (i != N_DIG - 1);
        end
    end

    always_comb begin
        nib_sel  = '0;
        dp_sel   = 1'b0;
        supp_sel = 1'b0;
        an_sel   = AN_OFF[N_DIG-1:0];
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                nib_sel   = disp_reg[4*k +: 4];
                dp_sel    = dp_reg[k];
                supp_sel  = lz_mask[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    hex7seg_decode u_dec (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    always_comb begin
        an_n  = AN_OFF[N_DIG-1:0];
        seg_n = SEG_OFF;
        dp_n  = 1'b1;
        if (state_nxt == S_SHOW) begin
            an_n  = an_sel;
            seg_n = (i_Lz && supp_sel) ? SEG_OFF : ~seg_dec;
            dp_n  = ~dp_sel;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            run      <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            disp_reg <= '0;
            dp_reg   <= '0;
            pend_reg <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            o_An     <= AN_OFF[N_DIG-1:0];
            o_Seg    <= SEG_OFF;
            o_Dp     <= 1'b1;
            o_Ack    <= 1'b0;
            o_Frame  <= 1'b0;
        end else begin
            run <= 1'b1;
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            // A load on the wrap cycle wins and defers commit to the next frame
            if (i_Load) begin
                pend_reg <= i_Data;
                pend_dp  <= i_Dp;
                pend     <= 1'b1;
            end else if (commit) begin
                disp_reg <= pend_reg;
                dp_reg   <= pend_dp;
                pend     <= 1'b0;
            end
            o_An    <= an_n;
            o_Seg   <= seg_n;
            o_Dp    <= dp_n;
            o_Ack   <= commit;
            o_Frame <= (cnt_nxt == '0) && (idx_nxt == '0);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a per-cycle reference model.
module tb_display_scan_ctrl;

    localparam int N = 4;
    localparam int SL = 10;
    localparam int BL = 2;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic [15:0] i_Data = '0;
    logic [3:0]  i_Dp = '0;
    logic        i_Lz = 1'b0;
    logic        i_Load = 1'b0;
    logic        o_Ack, o_Frame, o_Dp;
    logic [3:0]  o_An;
    logic [6:0]  o_Seg;

    display_scan_ctrl #(.N_DIG(N), .SCAN_LIM(SL), .BLANK_CYC(BL)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Data(i_Data), .i_Dp(i_Dp),
        .i_Lz(i_Lz), .i_Load(i_Load), .o_Ack(o_Ack), .o_Frame(o_Frame),
        .o_An(o_An), .o_Seg(o_Seg), .o_Dp(o_Dp)
    );

    always #5 i_Clk = ~i_Clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = -1;
    int cur = -1;
    bit active = 0;

    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    bit          m_has, m_ack, m_lz;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference: cycle c lies in slot (c/SL)%N at offset c%SL; loads commit at frame ends
    always @(negedge i_Clk) begin
        if (!active) begin
            cyc = -1;
            m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0;
            m_has = 0; m_ack = 0; m_lz = i_Lz;
        end else begin
            int c, d;
            bit shown, supp;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            cyc++;
            c = cyc % SL;
            d = (cyc / SL) % N;
            shown = (c >= BL);
            supp  = m_lz && d > 0 && ((m_disp >> (4 * d)) == 16'h0);
            e_an  = shown ? ~(4'b0001 << d) : 4'hF;
            e_seg = !shown ? 7'h7F : supp ? 7'h7F : ~seg_of(4'((m_disp >> (4 * d)) & 16'hF));
            e_dp  = shown ? ~m_dp[d] : 1'b1;
            chk("an",    8'(o_An),    8'(e_an));
            chk("seg",   8'(o_Seg),   8'(e_seg));
            chk("dp",    8'(o_Dp),    8'(e_dp));
            chk("frame", 8'(o_Frame), 8'(c == 0 && d == 0));
            chk("ack",   8'(o_Ack),   8'(m_ack));
            m_ack = 0;
            if (i_Load) begin
                m_pend = i_Data; m_pdp = i_Dp; m_has = 1;
            end else if (cyc % (N * SL) == N * SL - 1 && m_has) begin
                m_disp = m_pend; m_dp = m_pdp; m_has = 0; m_ack = 1;
            end
            m_lz = i_Lz;
        end
    end

    // Returns #1 after the edge that starts cycle n
    task automatic at_cycle(input int n);
        int guard = 0;
        if (cur == n) return;
        forever begin
            @(posedge i_Clk);
            if (cyc == n - 1) break;
            guard++;
            if (guard > 1000) begin
                $display("FAIL at_cycle timeout n=%0d", n);
                $fatal(1, "stuck");
            end
        end
        #1;
        cur = n;
    endtask

    task automatic expect_at(input int n, input string nm, input int sel, input logic [7:0] exp);
        logic [7:0] act;
        at_cycle(n);
        case (sel)
            0: act = 8'(o_An);
            1: act = 8'(o_Seg);
            2: act = 8'(o_Dp);
            3: act = 8'(o_Ack);
            default: act = 8'(o_Frame);
        endcase
        chk(nm, act, exp);
    endtask

    task automatic load(input int n, input logic [15:0] d, input logic [3:0] p);
        at_cycle(n);
        i_Data = d; i_Dp = p; i_Load = 1'b1;
        at_cycle(n + 1);
        i_Load = 1'b0;
    endtask

    task automatic do_reset();
        i_Reset = 1'b0;
        i_Load = 1'b0;
        active = 0;
        repeat (2) @(negedge i_Clk);
        chk("rst_an",  8'(o_An),  8'h0F);
        chk("rst_seg", 8'(o_Seg), 8'h7F);
        chk("rst_ack", 8'(o_Ack), 8'h00);
        #1;
        i_Reset = 1'b1;
        active = 1;
        cur = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        // Free-running scan after reset, zeros displayed
        do_reset();
        expect_at(0, "s1_frame0", 4, 8'h01);
        expect_at(1, "s1_an1", 0, 8'h0F);
        expect_at(2, "s1_an2", 0, 8'h0E);
        expect_at(12, "s1_an12", 0, 8'h0D);
        expect_at(12, "s1_seg12", 1, 8'h40);
        expect_at(40, "s1_frame40", 4, 8'h01);
        at_cycle(45);

        // Single load, committed at the next frame boundary
        do_reset();
        load(5, 16'h12AF, 4'b0100);
        expect_at(35, "s2_old", 1, 8'h40);
        expect_at(39, "s2_noack39", 3, 8'h00);
        expect_at(40, "s2_ack", 3, 8'h01);
        expect_at(42, "s2_d0", 1, 8'h0E);
        expect_at(55, "s2_d1", 1, 8'h08);
        expect_at(65, "s2_d2", 1, 8'h24);
        expect_at(65, "s2_dp2", 2, 8'h00);
        expect_at(75, "s2_d3", 1, 8'h79);
        at_cycle(80);

        // Last load wins, single ack
        do_reset();
        load(3, 16'h1111, 4'h0);
        load(20, 16'h2222, 4'h0);
        expect_at(40, "s3_ack", 3, 8'h01);
        expect_at(45, "s3_d0", 1, 8'h24);
        at_cycle(85);

        // Leading-zero suppression, then disabled live
        do_reset();
        i_Lz = 1'b1;
        load(3, 16'h0070, 4'h0);
        expect_at(45, "s4_d0", 1, 8'h40);
        expect_at(55, "s4_d1", 1, 8'h78);
        expect_at(65, "s4_an2", 0, 8'h0B);
        expect_at(65, "s4_d2", 1, 8'h7F);
        expect_at(75, "s4_an3", 0, 8'h07);
        expect_at(75, "s4_d3", 1, 8'h7F);
        at_cycle(81);
        i_Lz = 1'b0;
        expect_at(105, "s4_d2nolz", 1, 8'h40);
        expect_at(115, "s4_d3nolz", 1, 8'h40);

        // Load on the wrap cycle is deferred one frame
        do_reset();
        load(39, 16'h0005, 4'h0);
        expect_at(40, "s5_noack40", 3, 8'h00);
        expect_at(45, "s5_old", 1, 8'h40);
        expect_at(80, "s5_ack80", 3, 8'h01);
        expect_at(85, "s5_new", 1, 8'h12);

        // Reset mid-frame discards the pending value
        do_reset();
        load(10, 16'h1234, 4'hF);
        at_cycle(25);
        i_Reset = 1'b0;
        active = 0;
        #1;
        chk("s6_an", 8'(o_An), 8'h0F);
        chk("s6_seg", 8'(o_Seg), 8'h7F);
        chk("s6_dp", 8'(o_Dp), 8'h01);
        chk("s6_frame", 8'(o_Frame), 8'h00);
        do_reset();
        expect_at(40, "s6_noack", 3, 8'h00);
        expect_at(45, "s6_zero", 1, 8'h40);
        at_cycle(85);

        @(negedge i_Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed N-digit 7-segment display controller. It owns an internal scan-rate counter that divides i_Clk into per-digit time slots. It walks the digit anodes with a blanking gap before each digit (anti-ghosting) and decodes hex nibbles to segments. New display values are loaded through a pulse/ack handshake and committed only at frame boundaries, so a frame never shows mixed old and new digits.

Parameters:
N_DIG, 4, number of digits (2..8)
SCAN_LIM, 100000, i_Clk cycles per digit slot (>= 4)
BLANK_CYC, 1000, cycles at slot start with all anodes off (1 <= BLANK_CYC < SCAN_LIM)
CNT_W, $clog2(SCAN_LIM), slot counter width (localparam, not overridable)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous active-low reset
i_Data  in  4*N_DIG  hex nibbles; nibble k drives digit k (k=0 is least significant, rightmost)
i_Dp  in  N_DIG  decimal point per digit, 1 = lit
i_Lz  in  1  1 = suppress leading zeros
i_Load  in  1  1-cycle request to capture i_Data/i_Dp
o_Ack  out  1  1-cycle pulse: pending value committed to display
o_Frame  out  1  1-cycle pulse at start of each frame (digit 0 slot, cycle 0)
o_An  out  N_DIG  anode enables, active-low, at most one bit low
o_Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
o_Dp  out  1  decimal point, active-low

Behaviour:
- Reset (i_Reset=0, async): cnt=0, idx=0, state=S_BLANK, disp_reg=0, dp_reg=0, pend_reg=0, pend=0. Outputs: o_An=all 1, o_Seg=7'h7F, o_Dp=1, o_Ack=0, o_Frame=0. Reset mid-frame aborts the frame and discards any pending load.
- Slot counter: cnt counts 0..SCAN_LIM-1 and wraps to 0. On wrap, idx advances; idx wraps from N_DIG-1 to 0. One frame = N_DIG*SCAN_LIM cycles.
- FSM, 2 states, transitions evaluated every cycle:
  - S_BLANK: covers cnt 0..BLANK_CYC-1. o_An all 1, o_Seg 7'h7F, o_Dp 1. Moves to S_SHOW when cnt==BLANK_CYC-1.
  - S_SHOW: covers cnt BLANK_CYC..SCAN_LIM-1. o_An[idx]=0 and all other bits 1. o_Seg=~hex7(disp_reg nibble idx). o_Dp=~dp_reg[idx]. Moves to S_BLANK when cnt==SCAN_LIM-1.
- All outputs are registered. Output values follow the state, cnt and idx of the same cycle, computed from next-state logic with 0 added latency. Cycle 0 of each slot is already blanked.
- Hex table (gfedcba, active-high before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero suppression (i_Lz=1):
  - Digit k is blanked (segments 7'h7F) when k>0 and every nibble j with j>=k is 0.
  - Digit 0 is never suppressed.
  - A set decimal point on a suppressed digit is still driven.
  - i_Lz is sampled live, not latched.
- Load handshake:
  - i_Load=1 captures i_Data and i_Dp into pend_reg and sets pend=1.
  - A later load before commit overwrites pend_reg (last wins). There is no stall and no error.
  - Commit happens in the cycle idx wraps N_DIG-1 to 0 (the frame boundary). If pend=1 then: disp_reg/dp_reg <= pend_reg, pend <= 0, and o_Ack pulses in the first cycle of the new frame, coincident with o_Frame.
  - i_Load in the same cycle as the boundary wrap: the new data goes into pend_reg but is NOT committed at that boundary. It commits at the following boundary. The previously pending value, if any, is lost.
- o_Frame pulses once per frame, on the cycle where cnt==0 and idx==0. This includes the first frame after reset: the first pulse appears in the first cycle after reset release.

Decomposition:
- Package disp_pkg holds:
  - state enum {S_BLANK, S_SHOW}
  - constants SEG_OFF=7'h7F and AN_OFF (all ones)
  - a function hex7(nibble) returning the active-high segment code.
- One sub-module, hex7seg_decode: combinational, 4-bit in, 7-bit active-high out, wraps hex7. It is instantiated once and fed through an idx mux.
- Slot counter and FSM stay in display_scan_ctrl.

Test Plan:
(Bench parameters: N_DIG=4, SCAN_LIM=10, BLANK_CYC=2.)
- Reset release, no load -> o_Frame=1 on cycle 0. o_An=4'b1111 on cycles 0-1, 4'b1110 on cycles 2-9, 4'b1111 on 10-11, 4'b1101 on 12-19. o_Seg=~3F on all shown slots. o_Frame repeats every 40 cycles.
- Load i_Data=16'h12AF, i_Dp=4'b0100 at cycle 5 -> display unchanged until cycle 40. At cycle 40: o_Ack=1 and o_Frame=1. Digit 0 shows ~71 (F), digit 1 ~77 (A), digit 2 ~5B (2) with o_Dp=0, digit 3 ~06 (1).
- Two loads (16'h1111 at cycle 3, 16'h2222 at cycle 20) -> exactly one o_Ack at cycle 40. All digits show ~5B.
- Load 16'h0070 with i_Lz=1 -> digit 3 and digit 2 slots: o_An low but o_Seg=7'h7F. Digit 1 shows ~07 and digit 0 shows ~3F. With i_Lz=0, digits 3 and 2 show ~3F.
- i_Load asserted at cycle 39 (boundary wrap cycle) with 16'h0005 -> no o_Ack at cycle 40. o_Ack and new value appear at cycle 80.
- Assert i_Reset=0 at cycle 25 with a load pending -> outputs go to reset values immediately. After release, the display shows 0000 and no o_Ack ever occurs for the discarded load.
